// File: rtl/uo_uart_tx_stage.sv
// Serial transmitter for the tt_um output byte: start bit, LSB-first data,
// optional even parity, then one or two stop bits on a single idle-high line.
module uo_uart_tx_stage #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BW = 4;

  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]        cyc_cnt_q, cyc_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 parity_q, parity_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 in_ready_q, in_ready_d;
  logic                 tx_done_q, tx_done_d;

  logic accept;
  logic bit_end;
  logic last_data;
  logic last_stop;

  assign accept    = in_valid & in_ready_q;
  assign bit_end   = (cyc_cnt_q == CYC_LAST);
  assign last_data = (bit_cnt_q == DATA_LAST);
  assign last_stop = (bit_cnt_q == STOP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = START;
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end && last_data) state_d = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end && last_stop) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The bit counter restarts on every state change so it indexes data bits and stop bits alike.
  always_comb begin
    cyc_cnt_d = '0;
    if ((state_q != IDLE) && !bit_end) begin
      cyc_cnt_d = cyc_cnt_q + 1'b1;
    end

    bit_cnt_d = bit_cnt_q;
    if (state_d != state_q) begin
      bit_cnt_d = '0;
    end else if (bit_end && ((state_q == DATA) || (state_q == STOP))) begin
      bit_cnt_d = bit_cnt_q + 1'b1;
    end

    shift_d  = shift_q;
    parity_d = parity_q;
    if (accept) begin
      shift_d  = in_data;
      parity_d = ^in_data;
    end else if ((state_q == DATA) && bit_end) begin
      shift_d = shift_q >> 1;
    end
  end

  // Outputs are registered from the current state, so tx lags the state by one cycle.
  always_comb begin
    tx_d = 1'b1;
    unique case (state_q)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_q[0];
      PARITY:  tx_d = parity_q;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
    busy_d     = (state_d != IDLE);
    in_ready_d = (state_d == IDLE);
    tx_done_d  = (state_q == STOP) && (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      cyc_cnt_q  <= cyc_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      in_ready_q <= in_ready_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign tx       = tx_q;
  assign busy     = busy_q;
  assign in_ready = in_ready_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uo_uart_tx_stage.sv
// Scoreboard bench for uo_uart_tx_stage: three instances cover 4-clock frames with and
// without parity and a 1-clock, 2-stop-bit frame; one selected instance is driven at a time.
module tb_uo_uart_tx_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic [1:0] sel;

  logic [2:0] in_valid_w;
  wire  [2:0] in_ready_w;
  wire  [2:0] tx_w;
  wire  [2:0] busy_w;
  wire  [2:0] done_w;

  logic ready_s, tx_s, busy_s, done_s;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [63:0] tx;
    int          len;
    int          gap;
  } exp_t;

  exp_t exp_q[$];

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      in_valid_w[k] = in_valid && (sel == 2'(k));
    end
  end

  always_comb begin
    ready_s = in_ready_w[0];
    tx_s    = tx_w[0];
    busy_s  = busy_w[0];
    done_s  = done_w[0];
    case (sel)
      2'd1: begin
        ready_s = in_ready_w[1];
        tx_s    = tx_w[1];
        busy_s  = busy_w[1];
        done_s  = done_w[1];
      end
      2'd2: begin
        ready_s = in_ready_w[2];
        tx_s    = tx_w[2];
        busy_s  = busy_w[2];
        done_s  = done_w[2];
      end
      default: begin
        ready_s = in_ready_w[0];
        tx_s    = tx_w[0];
        busy_s  = busy_w[0];
        done_s  = done_w[0];
      end
    endcase
  end

  uo_uart_tx_stage #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(1)) u_plain (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_w[0]),
    .in_ready(in_ready_w[0]), .tx(tx_w[0]), .busy(busy_w[0]), .tx_done(done_w[0])
  );

  uo_uart_tx_stage #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1)) u_parity (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_w[1]),
    .in_ready(in_ready_w[1]), .tx(tx_w[1]), .busy(busy_w[1]), .tx_done(done_w[1])
  );

  uo_uart_tx_stage #(.CLKS_PER_BIT(1), .DATA_BITS(8), .PARITY_EN(0), .STOP_BITS(2)) u_fast (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid_w[2]),
    .in_ready(in_ready_w[2]), .tx(tx_w[2]), .busy(busy_w[2]), .tx_done(done_w[2])
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s sel=%0d actual=%h expected=%h", name, sel, act, exp);
    end
  endtask

  // Per-cycle line image of one frame for the currently selected instance.
  function automatic exp_t buildFrame(input logic [7:0] d);
    exp_t        e;
    logic [15:0] bits;
    int          nb;
    int          cpb;
    int          nstop;
    cpb   = (sel == 2'd2) ? 1 : 4;
    nstop = (sel == 2'd2) ? 2 : 1;
    bits  = '0;
    nb    = 0;
    bits[nb] = 1'b0;
    nb++;
    for (int i = 0; i < 8; i++) begin
      bits[nb] = d[i];
      nb++;
    end
    if (sel == 2'd1) begin
      bits[nb] = ^d;
      nb++;
    end
    for (int s = 0; s < nstop; s++) begin
      bits[nb] = 1'b1;
      nb++;
    end
    e.tx  = '0;
    e.len = 0;
    e.gap = -1;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < cpb; c++) begin
        e.tx[e.len] = bits[b];
        e.len++;
      end
    end
    return e;
  endfunction

  // Offers one byte, queues its expected frame, and returns #1 after the accept edge.
  task automatic applyStimulus(input logic [7:0] d, input int gap, input bit hold);
    exp_t e;
    int   n;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!ready_s && (n < 300)) begin
      @(negedge clk);
      n++;
    end
    if (!ready_s) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout sel=%0d actual=in_ready low expected=in_ready high", sel);
      in_valid = 1'b0;
      return;
    end
    e     = buildFrame(d);
    e.gap = gap;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) in_valid = 1'b0;
    checkOutput("accept_busy", 64'(busy_s), 64'd1);
    checkOutput("accept_ready", 64'(ready_s), 64'd0);
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy_s && (n < 300));
    if (busy_s) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_timeout sel=%0d actual=busy high expected=busy low", sel);
    end
    repeat (4) @(negedge clk);
  endtask

  // Monitor: records tx/busy/tx_done every cycle of a frame and compares the whole frame at its end.
  initial begin : monitor
    exp_t        cur;
    bit          active;
    int          idx;
    int          idle_cnt;
    logic [63:0] tx_a;
    logic [63:0] busy_a;
    logic [63:0] done_a;
    active   = 1'b0;
    idx      = 0;
    idle_cnt = -1;
    cur.tx   = '0;
    cur.len  = 0;
    cur.gap  = -1;
    tx_a     = '0;
    busy_a   = '0;
    done_a   = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        active   = 1'b0;
        idle_cnt = -1;
      end else begin
        if (!active) begin
          if (tx_s == 1'b0) begin
            if (exp_q.size() == 0) begin
              checks++;
              failures++;
              $display("[TB] FAIL unexpected_frame sel=%0d actual=start bit expected=idle line", sel);
            end else begin
              cur = exp_q.pop_front();
              if (cur.gap >= 0) checkOutput("idle_gap", 64'(idle_cnt), 64'(cur.gap));
              active = 1'b1;
              idx    = 0;
              tx_a   = '0;
              busy_a = '0;
              done_a = '0;
            end
          end else begin
            if (idle_cnt >= 0) idle_cnt++;
            if (done_s) begin
              checks++;
              failures++;
              $display("[TB] FAIL stray_done sel=%0d actual=1 expected=0", sel);
            end
          end
        end
        if (active) begin
          tx_a[idx]   = tx_s;
          busy_a[idx] = busy_s;
          done_a[idx] = done_s;
          idx++;
          if (idx == cur.len) begin
            checkOutput("frame_tx", tx_a, cur.tx);
            checkOutput("frame_busy", busy_a, (64'd1 << (cur.len - 1)) - 64'd1);
            checkOutput("frame_done", done_a, 64'd1 << (cur.len - 1));
            active   = 1'b0;
            idle_cnt = 0;
          end
        end
      end
    end
  end

  initial begin : stimulus
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    sel      = 2'd0;

    #12;
    checkOutput("reset_tx", 64'(tx_s), 64'd1);
    checkOutput("reset_busy", 64'(busy_s), 64'd0);
    checkOutput("reset_ready", 64'(ready_s), 64'd0);
    checkOutput("reset_done", 64'(done_s), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_ready", 64'(ready_s), 64'd1);

    $display("[TB] plain 0xA5");
    applyStimulus(8'hA5, -1, 1'b0);
    waitIdle();

    $display("[TB] parity 0x07 and 0xA5");
    sel = 2'd1;
    applyStimulus(8'h07, -1, 1'b0);
    waitIdle();
    applyStimulus(8'hA5, -1, 1'b0);
    waitIdle();

    $display("[TB] back-to-back 0x00 then 0xFF");
    sel = 2'd0;
    applyStimulus(8'h00, -1, 1'b1);
    applyStimulus(8'hFF, 1, 1'b0);
    waitIdle();

    $display("[TB] in_valid while busy");
    applyStimulus(8'hC3, -1, 1'b0);
    repeat (10) @(negedge clk);
    in_data  = 8'h3C;
    in_valid = 1'b1;
    #1;
    checkOutput("busy_ready_low", 64'(ready_s), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("busy_ready_still_low", 64'(ready_s), 64'd0);
    waitIdle();
    repeat (10) @(negedge clk);

    $display("[TB] reset during data bit 3");
    applyStimulus(8'h96, -1, 1'b0);
    repeat (18) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_tx", 64'(tx_s), 64'd1);
    checkOutput("abort_busy", 64'(busy_s), 64'd0);
    checkOutput("abort_ready", 64'(ready_s), 64'd0);
    checkOutput("abort_done", 64'(done_s), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rerelease_ready", 64'(ready_s), 64'd1);
    applyStimulus(8'h5A, -1, 1'b0);
    waitIdle();

    $display("[TB] one clock per bit, two stop bits, 0x81");
    sel = 2'd2;
    applyStimulus(8'h81, -1, 1'b0);
    waitIdle();
    applyStimulus(8'h3C, -1, 1'b1);
    applyStimulus(8'hE1, 1, 1'b0);
    waitIdle();

    repeat (10) @(negedge clk);
    checkOutput("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog actual=still running expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
